// File: rtl/dcache_wt.sv
`default_nettype none
// ============================================================================
// Module   : dcache_wt
// Purpose  : Direct-mapped, write-through, no-write-allocate data cache that
//            sits between the MEM stage and a word-wide, variable-latency
//            memory with a req/ready handshake.
// Ports    : clk, rst                 - clock, async active-high reset
//            cpu_addr/read/write/byte - MEM-stage request (LW/LB/SW/SB)
//            cpu_wdata, cpu_rdata     - store data in, load data out
//            hit                      - access satisfied this cycle
//            mem_req/we/addr/wdata/be - memory request, held until mem_ready
//            mem_rdata, mem_ready     - memory read word / one-cycle ack
// Revision : 1.0 - initial release
// ============================================================================
module dcache_wt #(
  parameter int LINES       = 64,
  parameter int BLOCK_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic        cpu_byte,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        hit,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int WSEL_W = $clog2(BLOCK_WORDS);
  localparam int OFF    = WSEL_W + 2;
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = 32 - OFF - IDX_W;
  localparam logic [WSEL_W-1:0] C_CNT_LAST = WSEL_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t r_state, w_next;

  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [31:0]       r_data [LINES*BLOCK_WORDS];

  logic [WSEL_W-1:0] r_cnt;
  logic [31-OFF:0]   r_base;   // {tag, index} of the block being filled
  logic [29:0]       r_waddr;  // word address of the pending store
  logic [31:0]       r_wdata;  // lane-replicated store word
  logic [3:0]        r_be;

  // CPU-side lookup
  logic [TAG_W-1:0]  w_cpu_tag;
  logic [IDX_W-1:0]  w_cpu_idx;
  logic [WSEL_W-1:0] w_cpu_wsel;
  logic              w_lookup_hit;
  logic [31:0]       w_rd_word;
  logic [7:0]        w_rd_byte;

  assign w_cpu_tag    = cpu_addr[31:OFF+IDX_W];
  assign w_cpu_idx    = cpu_addr[OFF+IDX_W-1:OFF];
  assign w_cpu_wsel   = cpu_addr[OFF-1:2];
  assign w_lookup_hit = r_valid[w_cpu_idx] && (r_tag[w_cpu_idx] == w_cpu_tag);
  assign w_rd_word    = r_data[{w_cpu_idx, w_cpu_wsel}];
  assign w_rd_byte    = w_rd_word[8*cpu_addr[1:0] +: 8];

  // Fill target
  logic [IDX_W-1:0]  w_fill_idx;
  logic [TAG_W-1:0]  w_fill_tag;
  assign w_fill_idx = r_base[IDX_W-1:0];
  assign w_fill_tag = r_base[31-OFF:IDX_W];

  // Store target (r_waddr holds addr[31:2], so address bit k is r_waddr[k-2])
  logic [IDX_W-1:0]  w_wr_idx;
  logic [TAG_W-1:0]  w_wr_tag;
  logic [WSEL_W-1:0] w_wr_wsel;
  logic              w_wr_hit;
  assign w_wr_idx  = r_waddr[OFF+IDX_W-3:OFF-2];
  assign w_wr_tag  = r_waddr[29:OFF+IDX_W-2];
  assign w_wr_wsel = r_waddr[OFF-3:0];
  assign w_wr_hit  = r_valid[w_wr_idx] && (r_tag[w_wr_idx] == w_wr_tag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Outputs are purely a function of state so that an async reset pulls
  // mem_req (and everything else) low without waiting for a clock edge.
  always_comb begin
    w_next    = r_state;
    hit       = 1'b0;
    cpu_rdata = 32'h0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_be    = 4'h0;
    case (r_state)
      IDLE: begin
        // A simultaneous read+write is handled as a write.
        if (cpu_write) begin
          w_next = WRITE;
        end else if (cpu_read) begin
          if (w_lookup_hit) begin
            hit       = 1'b1;
            cpu_rdata = cpu_byte ? {{24{w_rd_byte[7]}}, w_rd_byte} : w_rd_word;
          end else begin
            w_next = FILL;
          end
        end
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {r_base, r_cnt, 2'b00};
        if (mem_ready && (r_cnt == C_CNT_LAST)) w_next = IDLE;
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {r_waddr, 2'b00};
        mem_wdata = r_wdata;
        mem_be    = r_be;
        if (mem_ready) w_next = DONE;
      end
      DONE: begin
        // One-cycle completion pulse lets the pipeline move past the store.
        hit    = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_base  <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_valid <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cpu_write) begin
            r_waddr <= cpu_addr[31:2];
            r_wdata <= cpu_byte ? {4{cpu_wdata[7:0]}} : cpu_wdata;
            r_be    <= cpu_byte ? (4'b0001 << cpu_addr[1:0]) : 4'b1111;
          end else if (cpu_read && !w_lookup_hit) begin
            r_base <= cpu_addr[31:OFF];
          end
        end
        FILL: begin
          if (mem_ready) begin
            if (r_cnt == C_CNT_LAST) begin
              r_cnt               <= '0;
              r_valid[w_fill_idx] <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays need no reset: the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (r_state == FILL && mem_ready) begin
      r_data[{w_fill_idx, r_cnt}] <= mem_rdata;
      if (r_cnt == C_CNT_LAST) r_tag[w_fill_idx] <= w_fill_tag;
    end else if (r_state == WRITE && mem_ready && w_wr_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[b]) r_data[{w_wr_idx, w_wr_wsel}][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_wt.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_wt
// Purpose  : Self-checking bench for dcache_wt. Directed accesses push their
//            expected CPU responses and memory transactions into queues; a
//            monitor pops and compares whenever hit or a memory ack appears.
//            A memory responder acks each word two cycles after the request.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_wt;

  localparam int LAT      = 2;               // cycles from req to ready
  localparam int FILL_LAT = 1 + 4*(LAT + 1); // 13: miss cycle + 4 words
  localparam int WR_LAT   = LAT + 2;         // 4: idle, wait, ready, done

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cpu_addr = 32'h0;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic        cpu_byte = 1'b0;
  logic [31:0] cpu_wdata = 32'h0;
  logic [31:0] cpu_rdata;
  logic        hit;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ready = 1'b0;

  dcache_wt dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_byte  (cpu_byte),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .hit       (hit),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_read;
    logic [31:0] rdata;
    int          lat;
  } cpu_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_exp_t;

  cpu_exp_t    cpu_q[$];
  mem_exp_t    mem_q[$];
  logic [31:0] mem_model [logic [31:0]];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          issue_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : 32'h0;
  endfunction

  task automatic mem_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] w;
    w = mem_read(a);
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    mem_model[a] = w;
  endtask

  task automatic responder();
    int wcnt = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mem_ready <= 1'b0;
        wcnt = 0;
      end else if (mem_ready) begin
        mem_ready <= 1'b0;
      end else if (mem_req) begin
        if (wcnt == LAT - 1) begin
          wcnt = 0;
          mem_ready <= 1'b1;
          if (mem_we) mem_write(mem_addr, mem_wdata, mem_be);
          else        mem_rdata <= mem_read(mem_addr);
        end else begin
          wcnt++;
        end
      end
    end
  endtask

  task automatic monitor();
    cpu_exp_t ce;
    mem_exp_t me;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (hit) begin
          if (cpu_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_hit: got hit=1 at cycle %0d, expected no pending access", cyc);
          end else begin
            ce = cpu_q.pop_front();
            if (ce.is_read) chk("cpu_rdata", cpu_rdata, ce.rdata);
            chk("hit_latency", 32'(cyc - issue_cyc), 32'(ce.lat));
          end
        end
        if (mem_req && mem_ready) begin
          if (mem_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_mem: got access addr %h, expected none", mem_addr);
          end else begin
            me = mem_q.pop_front();
            chk("mem_we", {31'h0, mem_we}, {31'h0, me.we});
            chk("mem_addr", mem_addr, me.addr);
            if (me.we) begin
              chk("mem_wdata", mem_wdata, me.wdata);
              chk("mem_be", {28'h0, mem_be}, {28'h0, me.be});
            end
          end
        end
      end
      cyc++;
    end
  endtask

  // Drive one access and hold it until hit (bounded), then release.
  task automatic issue(input logic rd, input logic wr, input logic byt,
                       input logic [31:0] a, input logic [31:0] wd);
    int n;
    @(posedge clk); #1;
    cpu_read  = rd;
    cpu_write = wr;
    cpu_byte  = byt;
    cpu_addr  = a;
    cpu_wdata = wd;
    issue_cyc = cyc;
    n = 0;
    @(negedge clk);
    while (!hit && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!hit) chk("hit_timeout", {31'h0, hit}, 32'h1);
    @(posedge clk); #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic byt,
                         input logic [31:0] exp, input bit miss);
    if (miss) begin
      for (int k = 0; k < 4; k++)
        mem_q.push_back('{we: 1'b0, addr: (a & ~32'hF) + 32'(4*k), wdata: 32'h0, be: 4'h0});
    end
    cpu_q.push_back('{is_read: 1'b1, rdata: exp, lat: (miss ? FILL_LAT : 0)});
    issue(1'b1, 1'b0, byt, a, 32'h0);
  endtask

  task automatic do_write(input logic rd_too, input logic [31:0] a, input logic byt,
                          input logic [31:0] wd, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata);
    mem_q.push_back('{we: 1'b1, addr: a & ~32'h3, wdata: exp_wdata, be: exp_be});
    cpu_q.push_back('{is_read: 1'b0, rdata: 32'h0, lat: WR_LAT});
    issue(rd_too, 1'b1, byt, a, wd);
  endtask

  initial begin
    int acks;
    int n;
    mem_model[32'h100] = 32'h11;
    mem_model[32'h104] = 32'h22;
    mem_model[32'h108] = 32'h33;
    mem_model[32'h10C] = 32'h44;
    mem_model[32'h500] = 32'h5555_0000;
    mem_model[32'h300] = 32'hA0A0_A000;
    mem_model[32'h304] = 32'hA0A0_A001;
    mem_model[32'h3F0] = 32'h3F03_F000;
    mem_model[32'h3FC] = 32'hCAFE_F00D;

    fork
      monitor();
      responder();
    join_none

    // Reset values
    #3;
    chk("rst_hit", {31'h0, hit}, 32'h0);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_be", {28'h0, mem_be}, 32'h0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: cold miss fill, then same-cycle hit on the last word
    do_read(32'h100, 1'b0, 32'h11, 1'b1);
    do_read(32'h10C, 1'b0, 32'h44, 1'b0);

    // 2: word store hit, byte store to lane 2, word read back
    do_write(1'b0, 32'h100, 1'b0, 32'h1122_3344, 4'b1111, 32'h1122_3344);
    do_write(1'b0, 32'h102, 1'b1, 32'h1234_56AB, 4'b0100, 32'hABAB_ABAB);
    do_read(32'h100, 1'b0, 32'h11AB_3344, 1'b0);

    // 3: byte loads, negative and positive
    do_read(32'h102, 1'b1, 32'hFFFF_FFAB, 1'b0);
    do_read(32'h101, 1'b1, 32'h0000_0033, 1'b0);

    // 4: write miss does not allocate
    do_write(1'b0, 32'h2000, 1'b0, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    do_read(32'h2000, 1'b0, 32'hDEAD_BEEF, 1'b1);

    // 5: conflict eviction on index 16 (0x100 vs 0x500)
    do_read(32'h100, 1'b0, 32'h11AB_3344, 1'b0);
    do_read(32'h500, 1'b0, 32'h5555_0000, 1'b1);
    do_read(32'h100, 1'b0, 32'h11AB_3344, 1'b1);

    // read+write together acts as a write
    do_write(1'b1, 32'h104, 1'b0, 32'h7777_7777, 4'b1111, 32'h7777_7777);
    do_read(32'h104, 1'b0, 32'h7777_7777, 1'b0);

    // highest index
    do_read(32'h3F0, 1'b0, 32'h3F03_F000, 1'b1);
    do_read(32'h3FC, 1'b0, 32'hCAFE_F00D, 1'b0);

    // 6: reset after the second fill word aborts the fill
    mem_q.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0, be: 4'h0});
    mem_q.push_back('{we: 1'b0, addr: 32'h304, wdata: 32'h0, be: 4'h0});
    @(posedge clk); #1;
    cpu_read = 1'b1;
    cpu_byte = 1'b0;
    cpu_addr = 32'h300;
    acks = 0;
    n = 0;
    while (acks < 2 && n < 100) begin
      @(negedge clk);
      if (mem_req && mem_ready) acks++;
      n++;
    end
    chk("midfill_acks", 32'(acks), 32'd2);
    @(posedge clk); #1;
    chk("prerst_mem_req", {31'h0, mem_req}, 32'h1);
    chk("prerst_mem_addr", mem_addr, 32'h308);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("async_rst_mem_addr", mem_addr, 32'h0);
    chk("async_rst_hit", {31'h0, hit}, 32'h0);
    cpu_read = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midfill_mem_q_drained", 32'(mem_q.size()), 32'd0);
    do_read(32'h300, 1'b0, 32'hA0A0_A000, 1'b1);
    do_read(32'h304, 1'b0, 32'hA0A0_A001, 1'b0);

    repeat (5) @(posedge clk);
    chk("cpu_q_empty", 32'(cpu_q.size()), 32'd0);
    chk("mem_q_empty", 32'(mem_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/dcache_wt.md
Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the MEM stage and main memory.
- Serves LW/LB/SW/SB issued by the MEM stage.
- Produces the `hit` signal the control unit uses to gate pc_we and stall the pipeline while a memory access is outstanding.
- Talks to a word-wide, variable-latency memory through a req/ready handshake.

Parameters:
- LINES, 64, number of cache lines (power of 2).
- BLOCK_WORDS, 4, 32-bit words per line (power of 2, ≥2).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- cpu_addr  input  32  byte address from MEM stage
- cpu_read  input  1  load request (LW/LB)
- cpu_write  input  1  store request (SW/SB)
- cpu_byte  input  1  byte access (LB/SB) when 1, word access when 0
- cpu_wdata  input  32  store data; SB uses bits [7:0]
- cpu_rdata  output  32  load data; LB result is sign-extended
- hit  output  1  access satisfied this cycle
- mem_req  output  1  memory request, held until mem_ready
- mem_we  output  1  1 = write, 0 = read
- mem_addr  output  32  word-aligned address (bits [1:0] = 0)
- mem_wdata  output  32  write word
- mem_be  output  4  byte enables for writes
- mem_rdata  input  32  read word, valid when mem_ready
- mem_ready  input  1  one-cycle acknowledge per word

Behaviour:
- Address split:
  - OFF = log2(BLOCK_WORDS)+2 low bits; word select = addr[OFF-1:2].
  - index = next log2(LINES) bits; tag = the remaining upper bits.
- Storage: per line a valid bit, tag and BLOCK_WORDS data words.
- Byte lanes are little-endian: lane = addr[1:0], bits [8*lane+7 : 8*lane].
- States: IDLE, FILL, WRITE, DONE.
- Reset (async): state = IDLE, all valid bits = 0, fill counter = 0. Outputs take their reset values immediately: hit=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, cpu_rdata=0.
- If cpu_read and cpu_write are both asserted, the request is treated as a write.
- IDLE, read hit (valid && tag match):
  - hit=1 combinationally in the same cycle.
  - cpu_rdata = selected word; for a byte load, the sign-extended selected lane.
- IDLE, read miss:
  - Go to FILL and latch the block base address.
  - mem_req=1, mem_we=0, mem_addr = base + 4*cnt, starting at cnt=0.
- FILL:
  - On each mem_ready, write mem_rdata into word cnt and increment cnt.
  - After word BLOCK_WORDS-1: set valid, write tag, clear cnt, return to IDLE.
  - The retried lookup then hits.
  - Read-miss latency = sum of memory acks + 1 cycle.
  - hit=0 throughout FILL.
- IDLE, write (hit or miss):
  - Go to WRITE.
  - mem_req=1, mem_we=1, mem_addr = {addr[31:2],2'b00}.
  - Word store: mem_be=4'b1111, mem_wdata=cpu_wdata.
  - Byte store: mem_be = one-hot lane; mem_wdata = cpu_wdata[7:0] replicated to all 4 lanes.
- WRITE:
  - Hold all mem_* outputs stable until mem_ready.
  - On mem_ready: if the line is valid with a matching tag, update only the enabled lanes of the cached word. Then go to DONE.
  - A write miss does not allocate.
- DONE:
  - hit=1 for exactly one cycle, mem_req=0, then IDLE.
  - The pipeline advances on this cycle, so the store is not repeated.
- Idle cycles: with no cpu_read/cpu_write, hit=0 and mem_req=0. Unaffected because the control unit ignores hit for non-memory instructions.
- mem_req deasserts in the cycle after the final mem_ready of a transaction. It never toggles mid-transaction.
- Changes to CPU inputs during FILL or WRITE are ignored. The pipeline is stalled, so inputs are stable by contract.
- Reset mid-FILL or mid-WRITE:
  - Abort immediately; mem_req drops asynchronously.
  - The partially filled line stays invalid.
- Index wrap: the highest index (LINES-1) behaves like any other.
- A fill to an occupied index overwrites the resident line (no victim writeback, since the cache is write-through).

Test Plan:
1. Reset, then LW 0x0000_0100 with memory returning 0x11,0x22,0x33,0x44 at 2-cycle latency.
   - 4 read transactions to 0x100, 0x104, 0x108, 0x10C.
   - hit=0 until the fill ends, then hit=1 with cpu_rdata=0x11.
   - A subsequent LW 0x10C hits in the same cycle with 0x44.
2. SB 0xAB to 0x0000_0102 on a valid line holding word 0x11223344.
   - mem_be=4'b0100, mem_wdata=0xABABABAB.
   - hit is a 1-cycle pulse after mem_ready.
   - Then LW 0x100 hits with 0x11AB3344.
3. LB 0x0000_0102 after scenario 2 → cpu_rdata=0xFFFF_FFAB, hit in the same cycle.
4. SW 0xDEADBEEF to 0x0000_2000 (miss).
   - One write with mem_be=4'hF.
   - A following LW 0x2000 misses and triggers a fill (no allocate on write).
5. Conflict eviction:
   - LW 0x100, then LW at 0x100 + LINES*BLOCK_WORDS*4 (same index, different tag) → second access misses and refills.
   - LW 0x100 again → misses.
6. Assert rst after the 2nd fill word of a read miss.
   - mem_req=0 immediately.
   - After release, LW to the same address performs a full 4-word fill (line not valid).
